if_fetch_unit: RTL



---
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM, and fills
// the IF/ID register. Handles stalls, delay-slot branch redirects (including
// a branch that arrives during a stall), flushes and misaligned targets.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall event counters.
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0100)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_flush_pc,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_rom_cen,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_inst,
  output logic              o_id_valid,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [DATA_W-1:0] o_id_inst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       o_perf_fetch_cnt,
  output logic [31:0]       o_perf_stall_cnt,
`endif
  output logic              o_addr_err
);

  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pending_br;
  logic [ADDR_W-1:0] r_pending_tgt;
  logic              w_rom_cen;
  logic              w_do_flush;
  logic              w_do_stall;
  logic              w_do_fetch;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_pc_next;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, ROM enable and per-edge action select (FLUSH > STALL > normal)
  always_comb begin
    w_state_nxt = r_state;
    w_rom_cen   = 1'b0;
    w_do_flush  = 1'b0;
    w_do_stall  = 1'b0;
    w_do_fetch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_rom_cen  = !i_stall;
        w_do_flush = i_flush;
        w_do_stall = !i_flush && i_stall;
        w_do_fetch = !i_flush && !i_stall;
      end
    endcase
  end

  assign w_misaligned = |r_pc[1:0];

  // Redirect priority: live branch, then branch captured during a stall, then sequential
  assign w_pc_next = i_branch_en  ? i_branch_target :
                     r_pending_br ? r_pending_tgt   :
                                    r_pc + ADDR_W'(PC_STEP);

  // PC, pending redirect and IF/ID register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_pending_br  <= 1'b0;
      r_pending_tgt <= '0;
      o_id_valid    <= 1'b0;
      o_id_pc       <= '0;
      o_id_inst     <= '0;
      o_addr_err    <= 1'b0;
    end else if (w_do_flush) begin
      r_pc         <= i_flush_pc;
      r_pending_br <= 1'b0;
      o_id_valid   <= 1'b0;
      o_id_inst    <= '0;
      o_addr_err   <= 1'b0;
    end else if (w_do_stall) begin
      if (i_branch_en) begin
        r_pending_br  <= 1'b1;
        r_pending_tgt <= i_branch_target;
      end
    end else if (w_do_fetch) begin
      r_pc         <= w_pc_next;
      r_pending_br <= 1'b0;
      o_id_valid   <= 1'b1;
      o_id_pc      <= r_pc;
      o_id_inst    <= w_misaligned ? '0 : i_rom_inst;
      o_addr_err   <= w_misaligned;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_fetch_cnt <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (w_do_fetch) o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'd1;
      if (w_do_stall) o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign o_rom_cen  = w_rom_cen;
  assign o_rom_addr = r_pc;

endmodule
